core_frame_receiver: RTL and testbench

- Per-core receive stage directly downstream of the scheduler; one instance per core.
- Accepts 32-bit instruction beats broadcast on the scheduler-to-core bus, keeps only frames addressed to its core, and reassembles each frame of 16 x 16-bit instructions into one of two ping-pong instruction banks.
- Reports free capacity back to the scheduler via core_ready; presents completed frames to the core's fetch port in arrival order.

---
 rtl/gpu_pkg.sv | 13 +
 rtl/core_frame_receiver_instr_bank.sv | 34 +++
 rtl/core_frame_receiver.sv | 176 +++++++++++++++++
 tb/tb_core_frame_receiver.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the scheduler-to-core frame path: bank and receive FSM
// encodings plus the default instruction/frame geometry used by the scheduler.
package gpu_pkg;

  localparam int DEF_INSTR_SIZE  = 16;
  localparam int DEF_FRAME_SIZE  = 16;
  localparam int DEF_BUS_TO_CORE = 32;
  localparam int BEATS           = DEF_FRAME_SIZE * DEF_INSTR_SIZE / DEF_BUS_TO_CORE;

  typedef enum logic [1:0] {FREE, FILLING, FULL, EXEC} bank_state_e;
  typedef enum logic [1:0] {IDLE, RECV, DONE} rx_state_e;

endpackage

// File: rtl/core_frame_receiver_instr_bank.sv
// instr_bank: FRAME_SIZE x INSTR_SIZE register file, one two-word write port
// (an instruction pair per bus beat) and one asynchronous read port.
module instr_bank #(
  parameter int INSTR_SIZE = 16,
  parameter int FRAME_SIZE = 16
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [$clog2(FRAME_SIZE/2)-1:0] waddr,
  input  logic [INSTR_SIZE-1:0]           wdata_lo,
  input  logic [INSTR_SIZE-1:0]           wdata_hi,
  input  logic [$clog2(FRAME_SIZE)-1:0]   raddr,
  output logic [INSTR_SIZE-1:0]           rdata
);

  logic [INSTR_SIZE-1:0] mem_q [FRAME_SIZE];
  logic [INSTR_SIZE-1:0] mem_d [FRAME_SIZE];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[{waddr, 1'b0}] = wdata_lo;
      mem_d[{waddr, 1'b1}] = wdata_hi;
    end
  end

  // NOTE: storage has no reset; bank state flags, not contents, decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/core_frame_receiver.sv
// Per-core frame receiver: captures frames addressed to CORE_ID into two ping-pong
// instruction banks and hands them to fetch in order. Define RX_STATS_EN for frame counters.
module core_frame_receiver
  import gpu_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int CORE_NUM    = 16,
  parameter int INSTR_SIZE  = DEF_INSTR_SIZE,
  parameter int FRAME_SIZE  = DEF_FRAME_SIZE,
  parameter int BUS_TO_CORE = DEF_BUS_TO_CORE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_being_sent,
  input  logic [CORE_NUM-1:0]           bus_core_sel,
  input  logic                          bus_valid,
  input  logic [BUS_TO_CORE-1:0]        bus_data,
  output logic                          bus_ready,
  output logic                          core_ready,
  output logic                          frame_avail,
  input  logic [$clog2(FRAME_SIZE)-1:0] fetch_addr,
  output logic [INSTR_SIZE-1:0]         fetch_instr,
  input  logic                          exec_done,
  output logic                          rx_err
`ifdef RX_STATS_EN
  ,
  output logic [15:0]                   frames_rcvd,
  output logic [15:0]                   frames_aborted
`endif
);

  localparam int NBEATS = FRAME_SIZE * INSTR_SIZE / BUS_TO_CORE;
  localparam int BW     = $clog2(NBEATS);

  rx_state_e       state_q, state_d;
  bank_state_e     bank_q [2];
  bank_state_e     bank_d [2];
  logic            fill_ptr_q, fill_ptr_d;
  logic            exec_ptr_q, exec_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            core_ready_q, core_ready_d;
  logic            rx_err_q, rx_err_d;
  logic            selected, beat_acc, frame_done, frame_abort;
  logic [INSTR_SIZE-1:0] bank_rdata [2];
  logic            unused_sel;

  assign selected   = frame_being_sent && bus_core_sel[CORE_ID];
  assign unused_sel = ^bus_core_sel;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    fill_ptr_d  = fill_ptr_q;
    exec_ptr_d  = exec_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    rx_err_d    = rx_err_q;
    bus_ready   = 1'b0;
    frame_done  = 1'b0;
    frame_abort = 1'b0;

    case (state_q)
      IDLE: begin
        if (selected && bank_q[fill_ptr_q] == FREE) begin
          state_d            = RECV;
          bank_d[fill_ptr_q] = FILLING;
        end
      end
      RECV: begin
        bus_ready = 1'b1;
        if (!frame_being_sent) begin
          bank_d[fill_ptr_q] = FREE;
          beat_cnt_d         = '0;
          rx_err_d           = 1'b1;
          state_d            = IDLE;
          frame_abort        = 1'b1;
        end else if (bus_valid) begin
          if (beat_cnt_q == BW'(NBEATS - 1)) begin
            bank_d[fill_ptr_q] = FULL;
            fill_ptr_d         = ~fill_ptr_q;
            beat_cnt_d         = '0;
            state_d            = DONE;
            frame_done         = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // Hold off until the scheduler releases the bus so a frame is never taken twice.
        if (!frame_being_sent) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The exec side only touches FULL/EXEC banks, the fill side only FREE/FILLING ones.
    if (bank_q[exec_ptr_q] == FULL) begin
      bank_d[exec_ptr_q] = EXEC;
    end else if (bank_q[exec_ptr_q] == EXEC && exec_done) begin
      bank_d[exec_ptr_q] = FREE;
      exec_ptr_d         = ~exec_ptr_q;
    end

    core_ready_d = (bank_q[0] == FREE) || (bank_q[1] == FREE);
  end

  assign beat_acc = bus_valid && bus_ready;

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bank_q[0]    <= FREE;
      bank_q[1]    <= FREE;
      fill_ptr_q   <= 1'b0;
      exec_ptr_q   <= 1'b0;
      beat_cnt_q   <= '0;
      core_ready_q <= 1'b1;
      rx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      fill_ptr_q   <= fill_ptr_d;
      exec_ptr_q   <= exec_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      core_ready_q <= core_ready_d;
      rx_err_q     <= rx_err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    instr_bank #(
      .INSTR_SIZE (INSTR_SIZE),
      .FRAME_SIZE (FRAME_SIZE)
    ) u_bank (
      .clk      (clk),
      .we       (beat_acc && (fill_ptr_q == 1'(b))),
      .waddr    (beat_cnt_q),
      .wdata_lo (bus_data[INSTR_SIZE-1:0]),
      .wdata_hi (bus_data[2*INSTR_SIZE-1:INSTR_SIZE]),
      .raddr    (fetch_addr),
      .rdata    (bank_rdata[b])
    );
  end

  assign core_ready  = core_ready_q;
  assign frame_avail = (bank_q[exec_ptr_q] == EXEC);
  assign fetch_instr = bank_rdata[exec_ptr_q];
  assign rx_err      = rx_err_q;

`ifdef RX_STATS_EN
  logic [15:0] frames_rcvd_q, frames_rcvd_d;
  logic [15:0] frames_aborted_q, frames_aborted_d;

  always_comb begin
    frames_rcvd_d    = frames_rcvd_q;
    frames_aborted_d = frames_aborted_q;
    if (frame_done && frames_rcvd_q != 16'hffff)     frames_rcvd_d    = frames_rcvd_q + 16'd1;
    if (frame_abort && frames_aborted_q != 16'hffff) frames_aborted_d = frames_aborted_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frames_rcvd_q    <= '0;
      frames_aborted_q <= '0;
    end else begin
      frames_rcvd_q    <= frames_rcvd_d;
      frames_aborted_q <= frames_aborted_d;
    end
  end

  assign frames_rcvd    = frames_rcvd_q;
  assign frames_aborted = frames_aborted_q;
`endif

endmodule

// File: tb/tb_core_frame_receiver.sv
// Bench for core_frame_receiver: a core-0 instance scoreboarded frame by frame, plus a
// core-4 instance on the same bus to exercise destination filtering.
module tb_core_frame_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fbs = 1'b0;
  logic [15:0] sel = '0;
  logic        bus_valid = 1'b0;
  logic [31:0] bus_data = '0;
  logic [3:0]  fetch_addr = '0;
  logic        exec_done = 1'b0;
  logic        b_exec_done = 1'b0;

  logic        a_bus_ready, a_core_ready, a_frame_avail, a_rx_err;
  logic [15:0] a_fetch_instr;
  logic        b_bus_ready, b_core_ready, b_frame_avail, b_rx_err;
  logic [15:0] b_fetch_instr;
`ifdef RX_STATS_EN
  logic [15:0] a_frames_rcvd, a_frames_aborted, b_frames_rcvd, b_frames_aborted;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int a_ready_cnt = 0;
  int b_ready_cnt = 0;
  logic [255:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_bus_ready) a_ready_cnt++;
    if (b_bus_ready) b_ready_cnt++;
  end

  core_frame_receiver #(.CORE_ID(0)) dut_a (
    .clk              (clk),
    .reset            (reset),
    .frame_being_sent (fbs),
    .bus_core_sel     (sel),
    .bus_valid        (bus_valid),
    .bus_data         (bus_data),
    .bus_ready        (a_bus_ready),
    .core_ready       (a_core_ready),
    .frame_avail      (a_frame_avail),
    .fetch_addr       (fetch_addr),
    .fetch_instr      (a_fetch_instr),
    .exec_done        (exec_done),
    .rx_err           (a_rx_err)
`ifdef RX_STATS_EN
    ,
    .frames_rcvd      (a_frames_rcvd),
    .frames_aborted   (a_frames_aborted)
`endif
  );

  core_frame_receiver #(.CORE_ID(4)) dut_b (
    .clk              (clk),
    .reset            (reset),
    .frame_being_sent (fbs),
    .bus_core_sel     (sel),
    .bus_valid        (bus_valid),
    .bus_data         (bus_data),
    .bus_ready        (b_bus_ready),
    .core_ready       (b_core_ready),
    .frame_avail      (b_frame_avail),
    .fetch_addr       (fetch_addr),
    .fetch_instr      (b_fetch_instr),
    .exec_done        (b_exec_done),
    .rx_err           (b_rx_err)
`ifdef RX_STATS_EN
    ,
    .frames_rcvd      (b_frames_rcvd),
    .frames_aborted   (b_frames_aborted)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] frame_img(input logic [15:0] base);
    logic [255:0] img;
    for (int i = 0; i < 16; i++) img[16*i +: 16] = base + 16'(i);
    return img;
  endfunction

  // Drives nbeats beats of a frame whose instruction i is base+i; returns on the
  // negedge after the last accepted beat.
  task automatic send_frame(input logic [15:0] mask, input logic [15:0] base, input int nbeats,
                            input bit use_b, input bit done_on_last, input bit hold);
    int waited;
    @(negedge clk);
    fbs = 1'b1;
    sel = mask;
    for (int k = 0; k < nbeats; k++) begin
      bus_valid = 1'b1;
      bus_data  = {base + 16'(2*k + 1), base + 16'(2*k)};
      if (done_on_last && k == 7) exec_done = 1'b1;
      waited = 0;
      while (!(use_b ? b_bus_ready : a_bus_ready) && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 50) begin
        check("beat_ready_timeout", {31'b0, (use_b ? b_bus_ready : a_bus_ready)}, 1);
        break;
      end
      @(negedge clk);
      exec_done = 1'b0;
    end
    if (!hold) begin
      fbs       = 1'b0;
      sel       = '0;
      bus_valid = 1'b0;
    end
  endtask

  // Waits for the core-0 active frame and compares every word with the scoreboard head.
  task automatic check_active(input string tag);
    int waited = 0;
    logic [255:0] img;
    while (!a_frame_avail && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_avail"}, {31'b0, a_frame_avail}, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_frame"}, 32'(exp_q.size()), 1);
      return;
    end
    img = exp_q.pop_front();
    for (int i = 0; i < 16; i++) begin
      fetch_addr = 4'(i);
      #1;
      check(tag, {16'b0, a_fetch_instr}, {16'b0, img[16*i +: 16]});
      @(negedge clk);
    end
  endtask

  task automatic pulse_done();
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
  endtask

  initial begin
    int cnt0;

    // Reset
    repeat (2) @(negedge clk);
    check("rst_bus_ready", {31'b0, a_bus_ready}, 0);
    check("rst_core_ready", {31'b0, a_core_ready}, 1);
    check("rst_frame_avail", {31'b0, a_frame_avail}, 0);
    check("rst_rx_err", {31'b0, a_rx_err}, 0);
    reset = 1'b0;

    // Basic frame to core 0 (mask 000f); core 4 must ignore it
    cnt0 = b_ready_cnt;
    exp_q.push_back(frame_img(16'h1111));
    send_frame(16'h000f, 16'h1111, 8, 1'b0, 1'b0, 1'b0);
    check("lat_cycle1", {31'b0, a_frame_avail}, 0);
    @(negedge clk);
    check("lat_cycle2", {31'b0, a_frame_avail}, 1);
    fetch_addr = 4'd5;
    #1;
    check("fetch5", {16'b0, a_fetch_instr}, 32'h1116);
    check("core_ready_one_frame", {31'b0, a_core_ready}, 1);
    check("b_ignored_ready", 32'(b_ready_cnt - cnt0), 0);
    check("b_ignored_avail", {31'b0, b_frame_avail}, 0);
    check("b_ignored_core_ready", {31'b0, b_core_ready}, 1);
    @(negedge clk);
    check_active("f1111");
    pulse_done();

    // Frame to core 4 (mask 00f0); core 0 must ignore it
    cnt0 = a_ready_cnt;
    send_frame(16'h00f0, 16'h2000, 8, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("b_avail", {31'b0, b_frame_avail}, 1);
    fetch_addr = 4'd3;
    #1;
    check("b_fetch3", {16'b0, b_fetch_instr}, 32'h2003);
    check("a_ignored_ready", 32'(a_ready_cnt - cnt0), 0);
    check("a_ignored_avail", {31'b0, a_frame_avail}, 0);
    @(negedge clk);

    // Two frames fill both banks; a third is held off
    exp_q.push_back(frame_img(16'h3000));
    send_frame(16'h000f, 16'h3000, 8, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(frame_img(16'h4000));
    send_frame(16'h000f, 16'h4000, 8, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("both_full_core_ready", {31'b0, a_core_ready}, 0);
    cnt0 = a_ready_cnt;
    fbs = 1'b1;
    sel = 16'h000f;
    bus_valid = 1'b1;
    bus_data = 32'hdead_beef;
    repeat (4) @(negedge clk);
    check("blocked_no_ready", 32'(a_ready_cnt - cnt0), 0);
    fbs = 1'b0;
    sel = '0;
    bus_valid = 1'b0;
    @(negedge clk);
    check_active("f3000");
    pulse_done();
    @(negedge clk);
    check("core_ready_after_done", {31'b0, a_core_ready}, 1);
    check_active("f4000");
    pulse_done();

    // Abort after three beats, then a full frame into the same bank
    send_frame(16'h000f, 16'h5000, 3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("abort_rx_err", {31'b0, a_rx_err}, 1);
    check("abort_bus_ready", {31'b0, a_bus_ready}, 0);
    check("abort_no_avail", {31'b0, a_frame_avail}, 0);
    @(negedge clk);
    check("abort_core_ready", {31'b0, a_core_ready}, 1);
    exp_q.push_back(frame_img(16'h6000));
    send_frame(16'h000f, 16'h6000, 8, 1'b0, 1'b0, 1'b0);
    check_active("f6000");
    pulse_done();

    // exec_done coincides with the final beat into the other bank
    exp_q.push_back(frame_img(16'h7000));
    send_frame(16'h000f, 16'h7000, 8, 1'b0, 1'b0, 1'b0);
    check_active("f7000");
    exp_q.push_back(frame_img(16'h8000));
    send_frame(16'h000f, 16'h8000, 8, 1'b0, 1'b1, 1'b0);
    check("simul_gap", {31'b0, a_frame_avail}, 0);
    @(negedge clk);
    check("simul_next_avail", {31'b0, a_frame_avail}, 1);
    check_active("f8000");
    pulse_done();
    check("rx_err_sticky", {31'b0, a_rx_err}, 1);
`ifdef RX_STATS_EN
    check("stats_rcvd", {16'b0, a_frames_rcvd}, 6);
    check("stats_aborted", {16'b0, a_frames_aborted}, 1);
`endif

    // Reset in the middle of beat 5
    send_frame(16'h000f, 16'h9000, 4, 1'b0, 1'b0, 1'b1);
    bus_data = {16'h9009, 16'h9008};
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_bus_ready", {31'b0, a_bus_ready}, 0);
    check("mid_rst_core_ready", {31'b0, a_core_ready}, 1);
    check("mid_rst_frame_avail", {31'b0, a_frame_avail}, 0);
    check("mid_rst_rx_err", {31'b0, a_rx_err}, 0);
`ifdef RX_STATS_EN
    check("mid_rst_rcvd", {16'b0, a_frames_rcvd}, 0);
    check("mid_rst_aborted", {16'b0, a_frames_aborted}, 0);
`endif
    reset = 1'b0;
    fbs = 1'b0;
    sel = '0;
    bus_valid = 1'b0;
    exp_q.push_back(frame_img(16'ha000));
    send_frame(16'h000f, 16'ha000, 8, 1'b0, 1'b0, 1'b0);
    check_active("fa000");
    pulse_done();
    check("post_rst_rx_err", {31'b0, a_rx_err}, 0);
`ifdef RX_STATS_EN
    check("post_rst_rcvd", {16'b0, a_frames_rcvd}, 1);
`endif
    repeat (3) @(negedge clk);
    check("no_extra_frame", {31'b0, a_frame_avail}, 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
